uart_rx_framer: RTL
===================

UART_RX_FRAMER -- requirements
Module: uart_rx_framer

Interface
REQ-001 Parameter DATA_BITS, default 8: number of data bits per frame, LSB first.
REQ-002 Parameter SYNC_STAGES, default 2: number of synchroniser flops on rx.
REQ-003 clk_in  input  1  system clock; every flop is clocked on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rx  input  1  asynchronous serial line, idle high, 8N1 framing.
REQ-006 clk_div  input  1  bit-rate square wave from the frequency divider, synchronous to clk_in.
REQ-007 div_reset  output  1  registered output that holds the divider in reset while the framer is idle.
REQ-008 data  output  DATA_BITS  last correctly framed byte.
REQ-009 data_valid  output  1  one-cycle pulse when data updates.
REQ-010 frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 rx SHALL pass through a SYNC_STAGES flop synchroniser; rx_s names the synchronised value, and all decisions SHALL use rx_s.
REQ-013 tick SHALL be the rising edge of clk_div, detected as clk_div high while the registered clk_div_q is low (same-domain, no synchroniser).
REQ-014 The state machine SHALL have exactly four states: IDLE, START, DATA and STOP.
REQ-015 IDLE: div_reset = 1. When rx_s falls (previous rx_s = 1, current = 0), the FSM SHALL move to START and drive div_reset = 0 on the next cycle.
REQ-016 Divider contract: once released, the first tick arrives 5201 clk_in cycles later (mid start bit), then every 10402 cycles (mid each later bit).
REQ-017 START, on tick: if rx_s = 0, go to DATA with bit_cnt = 0; otherwise it is a false start, so go to IDLE with no output pulses.
REQ-018 DATA, on tick: shift right with rx_s entering the MSB and increment bit_cnt; after the DATA_BITS-th sample, go to STOP.
REQ-019 STOP, on tick: if rx_s = 1, load data from the shift register and pulse data_valid; otherwise pulse frame_err and leave data unchanged. In both cases go to IDLE.
REQ-020 data_valid and frame_err SHALL be registered, assert in the cycle after the stop-bit tick, and last exactly one clk_in cycle; they SHALL never assert together.
REQ-021 After STOP, div_reset SHALL reassert on the next cycle. No new start is accepted until rx_s has been seen high (a break or low line does not retrigger).
REQ-022 Ticks in IDLE SHALL be ignored; outside IDLE, rx edges between ticks SHALL be ignored.
REQ-023 bit_cnt SHALL be clog2(DATA_BITS+1) bits wide and SHALL never wrap within a frame.
REQ-024 data SHALL hold its value indefinitely until the next valid frame.

Reset
REQ-025 reset SHALL dominate every simultaneous event: tick, rx edge or stop-bit completion.
REQ-026 Reset values: state IDLE, div_reset 1, data 0, data_valid 0, frame_err 0, busy 0, bit_cnt 0, shift register 0, clk_div_q 0, synchroniser flops 1.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no pulse; reception resumes only at the next falling edge after reset.

Structure
REQ-028 Package uart_pkg SHALL hold the state enum, DATA_BITS_DEFAULT = 8, BIT_PERIOD_CLKS = 10402 and HALF_BIT_CLKS = 5201.
REQ-029 The synchroniser SHALL be a separate sub-module, sync_ff, parameterised by stage count.
REQ-030 The framer SHALL contain no baud counter of its own; all bit timing comes from clk_div.

Verification
REQ-031 The bench SHALL instance the real divider with div_reset wired to the divider's reset input, and drive rx at 10402 clk_in cycles per bit.
REQ-032 Send 0xA5 with stop = 1 -> data = 0xA5, a single data_valid pulse, frame_err = 0, div_reset high again within 2 cycles.
REQ-033 Send 0x3C with stop = 0, then hold rx low -> frame_err pulse, data keeps its previous value, no restart until rx returns high.
REQ-034 Send a 2000-cycle low glitch on rx, then high -> FSM returns to IDLE from START, no output pulses.
REQ-035 Send 0x00, 0xFF and 0x55 back-to-back with no idle gap -> three data_valid pulses with the matching values.
REQ-036 Assert reset during bit 4 of 0x81 -> all outputs at reset values, no pulse; the next frame 0x42 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and timing constants for the UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int DATA_BITS_DEFAULT = 8;
  localparam int BIT_PERIOD_CLKS   = 10402;
  localparam int HALF_BIT_CLKS     = 5201;

endpackage

// File: rtl/uart_rx_framer_if.sv
// Serial-side and byte-side signals of the receive framer.
interface uart_rx_framer_if #(
  parameter int DATA_BITS = uart_pkg::DATA_BITS_DEFAULT
);
  logic                 rx;
  logic                 clk_div;
  logic                 div_reset;
  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 frame_err;
  logic                 busy;

  modport master (
    input  rx, clk_div,
    output div_reset, data, data_valid, frame_err, busy
  );

  modport slave (
    output rx, clk_div,
    input  div_reset, data, data_valid, frame_err, busy
  );
endinterface

// File: rtl/sync_ff.sv
// Multi-flop synchroniser; flops come out of reset at the idle-high line level.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk_in,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      ff <= '1;
    end else begin
      ff[0] <= d;
      for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
    end
  end

  assign q = ff[STAGES-1];
endmodule

// File: rtl/uart_baud_div.sv
// Bit-rate divider: after release, clk_div rises half a bit later, then once per bit.
module uart_baud_div import uart_pkg::*; (
  input  logic clk_in,
  input  logic reset,
  output logic clk_div
);
  localparam int CW = $clog2(BIT_PERIOD_CLKS);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      cnt     <= '0;
      clk_div <= 1'b0;
    end else begin
      cnt <= (cnt == CW'(BIT_PERIOD_CLKS - 1)) ? '0 : cnt + 1'b1;
      if (cnt == CW'(HALF_BIT_CLKS - 1))        clk_div <= 1'b1;
      else if (cnt == CW'(BIT_PERIOD_CLKS - 1)) clk_div <= 1'b0;
    end
  end
endmodule

// File: rtl/uart_rx_framer.sv
// 8N1 receive framer: bit timing comes entirely from the external divider's clk_div.
module uart_rx_framer import uart_pkg::*; #(
  parameter int DATA_BITS   = DATA_BITS_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             reset,
  uart_rx_framer_if.master bus
);
  localparam int CNT_W = $clog2(DATA_BITS + 1);

  state_t               state;
  logic [CNT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 rx_s, rx_s_q, clk_div_q;
  logic                 tick, rx_fall;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_in (clk_in),
    .reset  (reset),
    .d      (bus.rx),
    .q      (rx_s)
  );

  // rx_s_q only falls after a real high, so a held-low line never retriggers.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      rx_s_q    <= 1'b1;
      clk_div_q <= 1'b0;
    end else begin
      rx_s_q    <= rx_s;
      clk_div_q <= bus.clk_div;
    end
  end

  assign tick    = bus.clk_div & ~clk_div_q;
  assign rx_fall = rx_s_q & ~rx_s;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state          <= IDLE;
      bus.div_reset  <= 1'b1;
      bus.data       <= '0;
      bus.data_valid <= 1'b0;
      bus.frame_err  <= 1'b0;
      bit_cnt        <= '0;
      shreg          <= '0;
    end else begin
      bus.data_valid <= 1'b0;
      bus.frame_err  <= 1'b0;
      case (state)
        IDLE: if (rx_fall) begin
          state         <= START;
          bus.div_reset <= 1'b0;
        end
        START: if (tick) begin
          if (!rx_s) begin
            state   <= DATA;
            bit_cnt <= '0;
          end else begin
            state         <= IDLE;
            bus.div_reset <= 1'b1;
          end
        end
        DATA: if (tick) begin
          shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == CNT_W'(DATA_BITS - 1)) state <= STOP;
        end
        STOP: if (tick) begin
          if (rx_s) begin
            bus.data       <= shreg;
            bus.data_valid <= 1'b1;
          end else begin
            bus.frame_err  <= 1'b1;
          end
          state         <= IDLE;
          bus.div_reset <= 1'b1;
        end
        default: begin
          state         <= IDLE;
          bus.div_reset <= 1'b1;
        end
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
endmodule
